// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file storage stage.
// AW is also the select width of the downstream 32:1 read muxes.
package regfile_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks a 5-bit index over every register, one per cycle,
// and tells the storage array when a write may be accepted.
module regfile_clr_seq
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_start,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_ok
);

    state_t        state;
    logic [AW-1:0] cnt;

    // Sequencer state, sweep index and the registered busy/done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(NREG - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Clear strobe comes straight from the state flop; a start request in IDLE
    // takes priority over a write in the same cycle, but is ignored in DONE
    always_comb begin
        clr_en  = (state == CLEAR);
        clr_idx = cnt;
        wr_ok   = (state == DONE) || ((state == IDLE) && !clr_start);
    end

endmodule

// File: rtl/regfile_bank.sv
// Register-file storage: 32 x N registers, one synchronous write port and a
// sequenced bulk clear. All registers are exposed in parallel for the read muxes.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int N       = 8,
    parameter int ZERO_R0 = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [N-1:0]    wdata,
    input  logic            clr_start,
    output logic [NREG*N-1:0] regs_flat,
    output logic            busy,
    output logic            clr_done,
    output logic            wr_err
);

    logic [N-1:0]  regs [NREG];
    logic          clr_en;
    logic [AW-1:0] clr_idx;
    logic          wr_ok;
    logic          wr_hit;

    regfile_clr_seq u_clr_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx),
        .busy      (busy),
        .clr_done  (clr_done),
        .wr_ok     (wr_ok)
    );

    // A write lands only when the sequencer allows it; with a hardwired r0 the
    // write to index 0 is discarded quietly rather than flagged
    always_comb begin
        wr_hit = we && wr_ok && !((ZERO_R0 != 0) && (waddr == '0));
    end

    // Storage array: clear strobe and write port are never active together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else if (clr_en) begin
            regs[clr_idx] <= '0;
        end else if (wr_hit) begin
            regs[waddr] <= wdata;
        end
    end

    // Flag any write request the sequencer refused (during a sweep or on collision)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= we && !wr_ok;
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign regs_flat[k*N +: N] = regs[k];
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: two instances (r0 hardwired and not)
// share stimulus and are compared every cycle against a timeline-based model.
module tb_regfile_bank;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           we = 1'b0;
    logic [4:0]     waddr = '0;
    logic [N-1:0]   wdata = '0;
    logic           clr_start = 1'b0;

    logic [32*N-1:0] flat_z, flat_n;
    logic busy_z, done_z, err_z;
    logic busy_n, done_n, err_n;

    int testCount = 0;
    int failCount = 0;

    // Model: register contents per instance plus the edge number of the last accepted sweep start
    logic [N-1:0] mem_z [32];
    logic [N-1:0] mem_n [32];
    int cyc = 0;
    int sweepStart = -1000;
    logic expBusy, expDone, expErr;

    regfile_bank #(.N(N), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .clr_start(clr_start), .regs_flat(flat_z), .busy(busy_z),
        .clr_done(done_z), .wr_err(err_z)
    );

    regfile_bank #(.N(N), .ZERO_R0(0)) dut_n (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .clr_start(clr_start), .regs_flat(flat_n), .busy(busy_n),
        .clr_done(done_n), .wr_err(err_n)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 32; k++) begin
            mem_z[k] = '0;
            mem_n[k] = '0;
        end
        sweepStart = -1000;
        expBusy = 1'b0;
        expDone = 1'b0;
        expErr  = 1'b0;
    endtask

    task automatic modelWrite();
        if (we) begin
            mem_n[waddr] = wdata;
            if (waddr != 5'd0) mem_z[waddr] = wdata;
        end
    endtask

    // One rising edge: edges 1..32 after a start clear register (edge-1),
    // edge 33 is the done cycle, which accepts writes but not a new start
    task automatic modelStep();
        int phase;
        cyc++;
        phase = cyc - sweepStart;
        expErr = 1'b0;
        if (phase >= 1 && phase <= 32) begin
            mem_z[phase-1] = '0;
            mem_n[phase-1] = '0;
            if (we) expErr = 1'b1;
        end else if (phase == 33) begin
            modelWrite();
        end else if (clr_start) begin
            sweepStart = cyc;
            if (we) expErr = 1'b1;
        end else begin
            modelWrite();
        end
        phase = cyc - sweepStart;
        expBusy = (phase >= 0 && phase <= 31);
        expDone = (phase == 32);
    endtask

    task automatic compareAll();
        logic [255:0] ez, en;
        ez = '0;
        en = '0;
        for (int k = 0; k < 32; k++) begin
            ez[k*N +: N] = mem_z[k];
            en[k*N +: N] = mem_n[k];
        end
        checkOutput("regs_r0zero", 256'(flat_z), ez);
        checkOutput("regs_r0free", 256'(flat_n), en);
        checkOutput("busy", 256'(busy_z), 256'(expBusy));
        checkOutput("clr_done", 256'(done_z), 256'(expDone));
        checkOutput("wr_err", 256'(err_z), 256'(expErr));
        checkOutput("ctrl_match", {253'd0, busy_n, done_n, err_n}, {253'd0, busy_z, done_z, err_z});
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [N-1:0] d, input logic c);
        @(negedge clk);
        we = w;
        waddr = a;
        wdata = d;
        clr_start = c;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, '0, 1'b0);
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once
    task automatic doReset();
        @(negedge clk);
        we = 1'b0;
        clr_start = 1'b0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        compareAll();
        checkOutput("rst_busy_n", 256'(busy_n), 256'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int busyCycles;
        int doneCount;
        modelReset();
        #1;
        compareAll();
        doReset();

        // Basic writes and read-back
        applyStimulus(1'b1, 5'd3, 8'hA5, 1'b0);
        applyStimulus(1'b1, 5'd31, 8'h3C, 1'b0);
        idle(1);

        // Register 0: hardwired in one instance, writable in the other
        applyStimulus(1'b1, 5'd0, 8'hFF, 1'b0);
        checkOutput("r0_zero", 256'(flat_z[7:0]), 256'h00);
        checkOutput("r0_free", 256'(flat_n[7:0]), 256'hFF);
        checkOutput("r0_no_err", 256'(err_z), 256'd0);

        // Full sweep over a filled array, counting busy cycles and done pulses
        for (int k = 1; k < 32; k++) applyStimulus(1'b1, 5'(k), 8'(k + 1), 1'b0);
        applyStimulus(1'b0, 5'd0, '0, 1'b1);
        busyCycles = 0;
        doneCount = 0;
        if (busy_z) busyCycles++;
        for (int i = 0; i < 36; i++) begin
            applyStimulus(1'b0, 5'd0, '0, 1'b0);
            if (busy_z) busyCycles++;
            if (done_z) doneCount++;
        end
        checkOutput("busy_len", 256'(busyCycles), 256'd32);
        checkOutput("done_count", 256'(doneCount), 256'd1);

        // Write during the 5th busy cycle is dropped
        applyStimulus(1'b1, 5'd7, 8'h99, 1'b0);
        applyStimulus(1'b0, 5'd0, '0, 1'b1);
        idle(4);
        applyStimulus(1'b1, 5'd7, 8'h55, 1'b0);
        idle(30);
        checkOutput("reg7_cleared", 256'(flat_z[7*N +: N]), 256'd0);

        // Collision of start and write in IDLE
        applyStimulus(1'b1, 5'd2, 8'h11, 1'b1);
        idle(34);
        checkOutput("reg2_cleared", 256'(flat_z[2*N +: N]), 256'd0);

        // Reset during a sweep, then normal writes resume
        for (int k = 1; k < 8; k++) applyStimulus(1'b1, 5'(k), 8'(8'hE0 + k), 1'b0);
        applyStimulus(1'b0, 5'd0, '0, 1'b1);
        idle(9);
        doReset();
        applyStimulus(1'b1, 5'd4, 8'h77, 1'b0);
        idle(35);
        checkOutput("reg4_after_rst", 256'(flat_z[4*N +: N]), 256'h77);

        // Random traffic with occasional sweeps
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          8'($urandom), ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
